// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared mode codes, FSM states and BCD helpers
package bcd_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd(input logic [3:0] nib);
    return nib <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational one-digit BCD adder with decimal correction
module bcd_digit_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;
  logic [4:0] t_adj;

  always_comb begin
    t     = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    t_adj = t + 5'd6;
    if (t > 5'd9) begin
      s  = t_adj[3:0];
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_seq_adder.sv
// rtl/bcd_seq_adder.sv - digit-serial BCD add/sub/accumulate with start/done handshake
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);
  import bcd_pkg::*;

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_q, c_d, sub_q, sub_d, cout_q, cout_d, err_q, err_d;

  logic [W-1:0]    op_a;
  logic            all_bcd;
  logic            last_digit;
  logic [3:0]      dig_a, dig_b, dig_y, dig_s;
  logic            dig_co;

  // Accumulate takes its A operand from the result register as of the start edge
  assign op_a       = (mode == MODE_ACC) ? sum_q : a;
  assign last_digit = (idx_q == IW'(DIGITS - 1));

  always_comb begin
    all_bcd = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!is_bcd(op_a[4*k +: 4]) || !is_bcd(b[4*k +: 4])) all_bcd = 1'b0;
    end
  end

  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        dig_a = a_q[4*k +: 4];
        dig_b = b_q[4*k +: 4];
      end
    end
    dig_y = sub_q ? (4'd9 - dig_b) : dig_b;
  end

  bcd_digit_add u_digit (
    .x  (dig_a),
    .y  (dig_y),
    .ci (c_q),
    .s  (dig_s),
    .co (dig_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (mode == MODE_CLR || !all_bcd) ? DONE : CALC;
      CALC: if (last_digit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    work_d = work_q;
    sum_d  = sum_q;
    idx_d  = idx_q;
    c_d    = c_q;
    sub_d  = sub_q;
    cout_d = cout_q;
    err_d  = err_q;
    if (state_q == IDLE && start) begin
      a_d    = op_a;
      b_d    = b;
      sub_d  = (mode == MODE_SUB);
      c_d    = (mode == MODE_SUB) ? ~cin : cin;
      idx_d  = '0;
      work_d = '0;
      // Clear wins over the digit check, so clearing never reports an error
      if (mode == MODE_CLR) begin
        sum_d  = '0;
        cout_d = 1'b0;
        err_d  = 1'b0;
      end else if (!all_bcd) begin
        sum_d  = '0;
        cout_d = 1'b0;
        err_d  = 1'b1;
      end
    end else if (state_q == CALC) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IW'(k)) work_d[4*k +: 4] = dig_s;
      end
      c_d   = dig_co;
      idx_d = idx_q + IW'(1);
      if (last_digit) begin
        sum_d  = work_d;
        cout_d = dig_co;
        err_d  = 1'b0;
        idx_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      work_q <= '0;
      sum_q  <= '0;
      idx_q  <= '0;
      c_q    <= 1'b0;
      sub_q  <= 1'b0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      work_q <= work_d;
      sum_q  <= sum_d;
      idx_q  <= idx_d;
      c_q    <= c_d;
      sub_q  <= sub_d;
      cout_q <= cout_d;
      err_q  <= err_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb/tb_bcd_seq_adder.sv - directed scoreboard bench for bcd_seq_adder
module tb_bcd_seq_adder;

  localparam int DIGITS = 4;

  logic        clk, rst_n, start, cin;
  logic [1:0]  mode;
  logic [15:0] a, b, sum;
  logic        cout, err, busy, done;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  bcd_seq_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int k = 3; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic do_op(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic [15:0] es, input logic ec, input logic ee,
                       input bit short_p, input bit poke);
    int          n;
    logic [15:0] held;
    exp_t        e;
    mode  = m;
    a     = av;
    b     = bv;
    cin   = ci;
    start = 1'b1;
    exp_q.push_back('{sum: es, cout: ec, err: ee});
    held  = sum;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    mode  = 2'($urandom);
    cin   = 1'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 3 * DIGITS) begin
      chk("busy_calc", busy, 1);
      chk("sum_hold", sum, held);
      start = (poke && n == 1);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, short_p ? 0 : DIGITS);
    chk("busy_at_done", busy, 0);
    e = exp_q.pop_front();
    chk("sum", sum, e.sum);
    chk("cout", cout, e.cout);
    chk("err", err, e.err);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic model_op(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci);
    int   r;
    logic c;
    if (m == 2'b01) begin
      r = bcd2int(av) - bcd2int(bv) - int'(ci);
      c = (r >= 0);
      if (r < 0) r += 10000;
    end else begin
      r = bcd2int(av) + bcd2int(bv) + int'(ci);
      c = (r >= 10000);
      r = r % 10000;
    end
    do_op(m, av, bv, ci, int2bcd(r), c, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    do_op(2'b00, 16'h0019, 16'h0001, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2'b00, 16'h9999, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(2'b01, 16'h0100, 16'h0001, 1'b0, 16'h0099, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(2'b01, 16'h0001, 16'h0003, 1'b0, 16'h9998, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2'b11, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op(2'b10, 16'hFFFF, 16'h0250, 1'b0, 16'h0250, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2'b10, 16'hFFFF, 16'h0250, 1'b0, 16'h0500, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2'b10, 16'hFFFF, 16'h0250, 1'b0, 16'h0750, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2'b00, 16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op(2'b00, 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(2'b01, 16'h0500, 16'h0250, 1'b1, 16'h0249, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(2'b00, 16'h0001, 16'h000F, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op(2'b00, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) begin
      @(posedge clk); #1;
      chk("no_extra_done", done, 0);
    end

    for (int i = 0; i < 4; i++) begin
      model_op(2'($urandom_range(0, 1)), int2bcd($urandom_range(0, 9999)),
               int2bcd($urandom_range(0, 9999)), 1'($urandom_range(0, 1)));
    end

    mode  = 2'b00;
    a     = 16'h8888;
    b     = 16'h1111;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_err", err, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    do_op(2'b00, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
